seg_pixel_streamer: RTL and testbench
=====================================

// Module: seg_pixel_streamer
// PURPOSE
//  Frame-buffered source of the 1-bit segmented hand image. It stores one binary frame (written pixel by
//  pixel by segmentation) and replays it in raster order with row/col tags and valid/ready flow control.
//  It is the transmit end of the object_image stream consumed by the palm/gesture feature blocks.
// PARAMETERS
//  IMG_W     160  pixels per row (col = 0..IMG_W-1)
//  IMG_H     120  rows per frame (row = 0..IMG_H-1)
//  ADDR_W    15   frame RAM address width; needs 2**ADDR_W >= IMG_W*IMG_H
//  LINE_GAP  4    idle cycles after each row; used only with SEG_LINE_GAP_EN
// PORTS
//  clk           in   1       single clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  wr_en         in   1       frame-RAM write strobe; ignored while busy=1
//  wr_addr       in   ADDR_W  write address = row*IMG_W+col
//  wr_data       in   1       pixel to store (1 = hand)
//  start         in   1       1-cycle pulse that begins one frame replay; ignored while busy=1
//  object_image  out  1       streamed pixel
//  pix_valid     out  1       object_image/row/col/sof/eol/eof are valid
//  pix_ready     in   1       sink accepts; transfer = pix_valid & pix_ready
//  row           out  8       row of current pixel
//  col           out  8       column of current pixel
//  sof/eol/eof   out  1 each  pixel is (0,0) / col==IMG_W-1 / (IMG_H-1,IMG_W-1)
//  busy          out  1       high from the cycle after start until done
//  done          out  1       1-cycle pulse the cycle after the eof transfer
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0. RAM contents undefined after power-up and kept across rst.
//  FSM: IDLE -start-> PRIME (read addr 0) -> STREAM -eof transfer-> DONE (done=1, busy=0) -> IDLE.
//    Per row, STREAM -eol transfer-> GAP -> STREAM when SEG_LINE_GAP_EN is defined and the row is not last.
//  Latency: start at cycle N gives busy=1 at N+1 and first pix_valid=1 at N+2, at (0,0) with sof=1.
//  Throughput: with pix_ready held at 1, one pixel per clock across a whole row. A read-ahead/skid
//    register hides the 1-cycle sync-RAM read.
//  Handshake: once pix_valid=1, all data outputs stay stable until the transfer. pix_valid never drops
//    without a transfer, except after eof and in GAP. No pixel is duplicated or skipped under any
//    pix_ready pattern.
//  Counters: col increments on each transfer and wraps IMG_W-1 -> 0 with row+1. After eof, row/col
//    return to 0. Address = row*IMG_W+col, kept as a running counter (no multiplier).
//  Writes: accepted only in IDLE; wr_addr >= IMG_W*IMG_H is dropped. A write and start in the same
//    cycle: the write lands first and that frame sees it.
//  start while busy: ignored, no restart. rst mid-frame: outputs clear immediately. The next start
//    replays from (0,0) with RAM intact.
//  Edge widths: IMG_W=1 gives sof&eol on the same pixel. IMG_H=1 gives eol&eof on the same pixel.
// CONFIGURATION
//  SEG_LINE_GAP_EN defined: after each eol transfer except the last row, pix_valid=0 for exactly
//    LINE_GAP cycles (GAP state, down-counter), then the next row starts.
//  SEG_LINE_GAP_EN undefined: no GAP state, rows are back-to-back, LINE_GAP is unused.
// STRUCTURE
//  Package seg_stream_pkg: IMG_W/IMG_H defaults, pixel-count constant, state typedef
//    (IDLE, PRIME, STREAM, GAP, DONE).
//  Sub-module seg_frame_ram: 1-bit, 2**ADDR_W deep, 1 write port, 1 sync-read port with 1-cycle latency.
//  Top level: FSM, row/col/address counters, read-ahead buffer, flag generation.
// TESTING
//  1. Checkerboard load; start; pix_ready=1 -> 19200 pixels on consecutive cycles from start+2;
//     sof at (0,0); 120 eol; eof at (119,159); done at eof+1; data matches.
//  2. Same frame, pix_ready toggling 1,0 -> outputs stable during every stall; exactly 19200 transfers;
//     order identical to test 1.
//  3. start and wr_en(addr 0, data flipped) pulsed at pixel 100 -> no restart; next frame still shows
//     the old pixel at (0,0).
//  4. rst asserted at pixel 5000 -> all outputs 0 in the same cycle; re-start streams from (0,0) with
//     correct data.
//  5. SEG_LINE_GAP_EN, LINE_GAP=4 -> pix_valid low for exactly 4 cycles after each of the first 119 eol;
//     none after eof. Without the macro: no gaps.
//  6. IMG_W=4, IMG_H=3, random pixels, random pix_ready -> 12 transfers; eol at cols 3; eof at (2,3);
//     wr_addr=12 dropped.

Source files
------------

// File: rtl/seg_stream_pkg.sv
// seg_stream_pkg: frame geometry defaults and FSM state encoding for the segmented pixel streamer
package seg_stream_pkg;
  localparam int IMG_W_DEF   = 160;
  localparam int IMG_H_DEF   = 120;
  localparam int IMG_PIX_DEF = IMG_W_DEF * IMG_H_DEF;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_PRIME  = 3'd1;
  localparam state_t S_STREAM = 3'd2;
  localparam state_t S_GAP    = 3'd3;
  localparam state_t S_DONE   = 3'd4;
endpackage

// File: rtl/seg_frame_ram.sv
// seg_frame_ram: 1-bit frame RAM with one write port and one sync-read port (1-cycle latency)
module seg_frame_ram #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic              wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic              rdata_o
);
  logic mem_q [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/seg_pixel_streamer.sv
// seg_pixel_streamer: stores one binary frame and replays it in raster order with valid/ready.
// Define SEG_LINE_GAP_EN to insert LINE_GAP idle cycles after every row except the last.
module seg_pixel_streamer
  import seg_stream_pkg::*;
#(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int ADDR_W   = 15,
  parameter int LINE_GAP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  input  logic              start,
  output logic              object_image,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        row,
  output logic [7:0]        col,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);
  localparam int PIX = IMG_W * IMG_H;
`ifdef SEG_LINE_GAP_EN
  localparam int GAP_CYC = LINE_GAP;
`else
  localparam int GAP_CYC = 0 * LINE_GAP;
`endif
  state_t state_q, state_d;
  logic [7:0] row_q, row_d, col_q, col_d, gap_q, gap_d;
  logic [ADDR_W-1:0] addr_q, addr_d, rd_addr;
  logic rd_data, xfer, last_col, last_row, ram_we;
  assign pix_valid    = state_q == S_STREAM;
  assign xfer         = pix_valid & pix_ready;
  assign last_col     = col_q == 8'(IMG_W - 1);
  assign last_row     = row_q == 8'(IMG_H - 1);
  assign sof          = pix_valid & (row_q == '0) & (col_q == '0);
  assign eol          = pix_valid & last_col;
  assign eof          = eol & last_row;
  assign object_image = pix_valid & rd_data;
  assign row          = row_q;
  assign col          = col_q;
  assign busy         = (state_q == S_PRIME) | (state_q == S_STREAM) | (state_q == S_GAP);
  assign done         = state_q == S_DONE;
  assign ram_we       = wr_en & (state_q == S_IDLE) & (32'(wr_addr) < PIX);
  // Reading the displayed address again on a stall keeps the RAM output register stable.
  assign rd_addr      = xfer ? addr_q + ADDR_W'(1) : addr_q;
  seg_frame_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = rd_addr;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE:   state_d = start ? S_PRIME : S_IDLE;
      S_PRIME:  state_d = S_STREAM;
      S_STREAM: if (xfer) begin
        col_d = last_col ? '0 : col_q + 8'd1;
        row_d = last_col ? row_q + 8'd1 : row_q;
        if (last_row && last_col) begin
          state_d = S_DONE;
          row_d   = '0;
          addr_d  = '0;
        end else if (last_col && GAP_CYC > 0) begin
          state_d = S_GAP;
          gap_d   = 8'(GAP_CYC - 1);
        end
      end
      S_GAP: begin
        gap_d   = gap_q - 8'd1;
        state_d = (gap_q == '0) ? S_STREAM : S_GAP;
      end
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      gap_q   <= gap_d;
    end
  end
endmodule

// File: tb/tb_seg_pixel_streamer.sv
// tb_seg_pixel_streamer: directed checks of a 160x120 and a 4x3 streamer instance
module tb_seg_pixel_streamer;
  localparam int W = 160, H = 120, PIX = W * H;
`ifdef SEG_LINE_GAP_EN
  localparam int GAP_EXP = 4, GAP_EXP_S = 2;
`else
  localparam int GAP_EXP = 0, GAP_EXP_S = 0;
`endif
  logic clk = 0, rst = 1;
  logic wr_en = 0, wr_data = 0, start = 0, pix_ready = 0;
  logic [14:0] wr_addr = '0;
  logic object_image, pix_valid, sof, eol, eof, busy, done;
  logic [7:0] row, col;
  logic s_wr_en = 0, s_wr_data = 0, s_start = 0, s_ready = 0;
  logic [3:0] s_wr_addr = '0;
  logic s_image, s_valid, s_sof, s_eol, s_eof, s_busy, s_done;
  logic [7:0] s_row, s_col;
  logic img [PIX];
  logic s_img [12];
  int checks = 0, passes = 0;

  always #5 clk = ~clk;

  seg_pixel_streamer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
    .object_image(object_image), .pix_valid(pix_valid), .pix_ready(pix_ready), .row(row), .col(col),
    .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done)
  );

  seg_pixel_streamer #(.IMG_W(4), .IMG_H(3), .ADDR_W(4), .LINE_GAP(2)) dut_s (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .start(s_start),
    .object_image(s_image), .pix_valid(s_valid), .pix_ready(s_ready), .row(s_row), .col(s_col),
    .sof(s_sof), .eol(s_eol), .eof(s_eof), .busy(s_busy), .done(s_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] outs();
    return {pix_valid, object_image, row, col, sof, eol, eof, busy, done};
  endfunction

  // mode 0: ready held high, 1: ready toggles 1,0, 2: random ready
  task automatic run_frame(input int mode, input int inj_at, input int rst_at);
    int i, gap, cyc, r, c;
    logic rdy;
    start = 1;
    @(negedge clk);
    start = 0;
    wr_en = 0;
    chk("busy_after_start", {busy, pix_valid}, 2'b10);
    pix_ready = 1;
    @(negedge clk);
    i = 0; gap = 0; cyc = 0;
    while (i < PIX && cyc < 60000) begin
      if (i == rst_at) begin
        rst = 1;
        #1 chk("rst_clears", outs(), 0);
        @(negedge clk);
        rst = 0;
        return;
      end
      start = (cyc == inj_at);
      wr_en = start;
      if (gap > 0) begin
        chk("gap_idle", pix_valid, 0);
        gap--;
      end else begin
        r = i / W; c = i % W;
        chk("pixel", {pix_valid, object_image, row, col, sof, eol, eof, busy},
            {1'b1, img[i], 8'(r), 8'(c), r == 0 && c == 0, c == W - 1, r == H - 1 && c == W - 1, 1'b1});
        rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
        pix_ready = rdy;
        if (rdy) begin
          if (c == W - 1 && r != H - 1) gap = GAP_EXP;
          i++;
        end
      end
      cyc++;
      @(negedge clk);
    end
    start = 0;
    wr_en = 0;
    chk("frame_complete", i, PIX);
    chk("done_pulse", {done, busy, pix_valid}, 3'b100);
    @(negedge clk);
    chk("idle_after_done", {done, busy, pix_valid, row, col}, 0);
  endtask

  initial begin
    int i, gap, cyc, r, c;
    logic rdy;
    @(negedge clk);
    #1 chk("reset_outputs", outs(), 0);
    chk("reset_outputs_s", {s_valid, s_image, s_row, s_col, s_sof, s_eol, s_eof, s_busy, s_done}, 0);
    rst = 0;
    @(negedge clk);
    chk("idle_after_reset", outs(), 0);
    for (int k = 0; k < PIX; k++) begin
      img[k] = 1'((k / W + k % W) & 1);
      wr_en = 1; wr_addr = 15'(k); wr_data = img[k];
      @(negedge clk);
    end
    wr_en = 0;
    run_frame(0, -1, -1);
    run_frame(1, -1, -1);
    // Mid-frame start plus write to (0,0) must be ignored; reset at pixel 5000.
    wr_addr = '0; wr_data = ~img[0];
    run_frame(0, 100, 5000);
    run_frame(0, -1, 2000);
    // Write landing in the same cycle as start is seen by that frame.
    img[0] = ~img[0];
    wr_en = 1; wr_addr = '0; wr_data = img[0];
    run_frame(2, -1, 300);
    for (int k = 0; k < 12; k++) begin
      s_img[k] = 1'($urandom_range(0, 1));
      s_wr_en = 1; s_wr_addr = 4'(k); s_wr_data = s_img[k];
      @(negedge clk);
    end
    s_wr_addr = 4'd12; s_wr_data = ~s_img[11];
    @(negedge clk);
    s_wr_en = 0;
    s_start = 1;
    @(negedge clk);
    s_start = 0;
    s_ready = 1;
    @(negedge clk);
    i = 0; gap = 0; cyc = 0;
    while (i < 12 && cyc < 500) begin
      if (gap > 0) begin
        chk("s_gap_idle", s_valid, 0);
        gap--;
      end else begin
        r = i / 4; c = i % 4;
        chk("s_pixel", {s_valid, s_image, s_row, s_col, s_sof, s_eol, s_eof, s_busy},
            {1'b1, s_img[i], 8'(r), 8'(c), i == 0, c == 3, i == 11, 1'b1});
        rdy = 1'($urandom_range(0, 1));
        s_ready = rdy;
        if (rdy) begin
          if (c == 3 && r != 2) gap = GAP_EXP_S;
          i++;
        end
      end
      cyc++;
      @(negedge clk);
    end
    chk("s_frame_complete", i, 12);
    chk("s_done_pulse", {s_done, s_busy, s_valid}, 3'b100);
    @(negedge clk);
    chk("s_idle_after_done", {s_done, s_busy, s_valid, s_row, s_col}, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
